// File: rtl/pixel_pkg.sv
// Shared types and default geometry for the pixel readout controller.
package pixel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int unsigned DEF_ROW    = 4;
  localparam int unsigned DEF_COL    = 4;
  localparam int unsigned DEF_SETTLE = 2;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_row_buffer.sv
// Holds one captured pixel row; the pixel at sel_i is presented on pix_o.
module pixel_row_buffer
  import pixel_pkg::*;
#(
  parameter  int unsigned COL = DEF_COL,
  localparam int unsigned CW  = idx_width(COL)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [COL*8-1:0] row_i,
  input  logic [CW-1:0]   sel_i,
  output logic [7:0]      pix_o
);

  logic [7:0] buf_q [COL];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < COL; i++) buf_q[i] <= '0;
    end else if (load_i) begin
      for (int unsigned i = 0; i < COL; i++) buf_q[i] <= row_i[8*i +: 8];
    end
  end

  always_comb begin
    pix_o = '0;
    if (32'(sel_i) < COL) pix_o = buf_q[sel_i];
  end

endmodule

// File: rtl/pixel_readout_ctrl.sv
// Row-by-row pixel array readout: select a row, let it settle, capture it,
// then stream its pixels out over a valid/ready handshake.
module pixel_readout_ctrl
  import pixel_pkg::*;
#(
  parameter  int unsigned ROW    = DEF_ROW,
  parameter  int unsigned COL    = DEF_COL,
  parameter  int unsigned SETTLE = DEF_SETTLE,
  localparam int unsigned RW     = idx_width(ROW),
  localparam int unsigned CW     = idx_width(COL)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic [ROW-1:0]   read_o,
  input  logic [COL*8-1:0] data_i,
  output logic             pix_valid_o,
  input  logic             pix_ready_i,
  output logic [7:0]       pix_data_o,
  output logic [RW-1:0]    pix_row_o,
  output logic [CW-1:0]    pix_col_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             overrun_o
);

  localparam logic [RW-1:0] ROW_LAST    = RW'(ROW - 1);
  localparam logic [CW-1:0] COL_LAST    = CW'(COL - 1);
  localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE - 1);

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      pix_data_q, pix_data_d;
  logic [ROW-1:0]  read_q, read_d;
  logic            valid_q, busy_q, done_q, ovr_q;
  logic            load;
  logic [CW-1:0]   next_col;
  logic [7:0]      buf_pix;

  assign next_col = col_q + CW'(1);

  pixel_row_buffer #(.COL(COL)) u_row_buf (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (load),
    .row_i  (data_i),
    .sel_i  (next_col),
    .pix_o  (buf_pix)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    cnt_d      = cnt_q;
    pix_data_d = pix_data_q;
    load       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SELECT;
          row_d   = '0;
          col_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_SELECT: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_CAPTURE: begin
        // Column 0 goes straight from the array; the buffer serves columns 1+.
        load       = 1'b1;
        pix_data_d = data_i[7:0];
        col_d      = '0;
        state_d    = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (pix_ready_i) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_SELECT;
              row_d   = row_q + RW'(1);
              cnt_d   = '0;
            end
          end else begin
            col_d      = next_col;
            pix_data_d = buf_pix;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    read_d = '0;
    if (state_d == ST_SELECT || state_d == ST_CAPTURE) read_d[row_d] = 1'b1;
  end

  // Outputs are registered from next-state so they line up with state_q.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      cnt_q      <= '0;
      pix_data_q <= '0;
      read_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      pix_data_q <= pix_data_d;
      read_q     <= read_d;
      valid_q    <= (state_d == ST_SHIFT);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
      ovr_q      <= ovr_q | (start_i && state_q != ST_IDLE);
    end
  end

  assign read_o       = read_q;
  assign pix_valid_o  = valid_q;
  assign pix_data_o   = pix_data_q;
  assign pix_row_o    = row_q;
  assign pix_col_o    = col_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign overrun_o    = ovr_q;

endmodule
